// File: rtl/aftab_booth_divider_if.sv
// Handshake and data bundle for the AAU sequential signed divider.
interface aftab_booth_divider_if #(
    parameter int size = 33
);
    logic            start;
    logic [size-1:0] Dividend;
    logic [size-1:0] Divisor;
    logic [size-1:0] Q;
    logic [size-1:0] R;
    logic            busy;
    logic            done;
    logic            dbz;

    modport master (
        output start, Dividend, Divisor,
        input  Q, R, busy, done, dbz
    );

    modport slave (
        input  start, Dividend, Divisor,
        output Q, R, busy, done, dbz
    );
endinterface

// File: rtl/aftab_booth_divider.sv
// Sequential signed divider: magnitude restoring division, one quotient bit
// per clock, followed by a sign-correction step. Operands arrive already
// sign- or zero-extended, so the same block covers DIV/DIVU/REM/REMU.
module aftab_booth_divider #(
    parameter int size = 33
) (
    input logic                  clk,
    input logic                  rst,
    aftab_booth_divider_if.slave bus
);
    localparam int CW = $clog2(size);
    localparam logic [CW-1:0]   LAST   = CW'(size - 1);
    localparam logic [size-1:0] MINVAL = {1'b1, {(size-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, INIT, ITER, FIX, DONE} state_t;

    state_t          state, stateNext;
    logic [size-1:0] dividendReg, divisorReg;
    logic [size-1:0] absDivisor;
    logic [size-1:0] qsr;
    logic [size:0]   rem;
    logic [CW-1:0]   count;
    logic [size:0]   shifted;
    logic [size:0]   trial;
    logic            signDiff;
    logic            overflow;

    // Unsigned magnitude; the most negative value maps to 2^(size-1).
    function automatic logic [size-1:0] absVal(input logic [size-1:0] x);
        return x[size-1] ? -x : x;
    endfunction

    assign shifted  = {rem[size-1:0], qsr[size-1]};
    assign trial    = shifted - {1'b0, absDivisor};
    assign signDiff = dividendReg[size-1] ^ divisorReg[size-1];
    assign overflow = (dividendReg == MINVAL) && (divisorReg == '1);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    // Next-state decode.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.start) stateNext = INIT;
            INIT:    stateNext = (divisorReg == '0) ? DONE : ITER;
            ITER:    if (count == LAST) stateNext = FIX;
            FIX:     stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Datapath and registered outputs; busy/done follow the upcoming state
    // so they line up with the state they describe without comb outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dividendReg <= '0;
            divisorReg  <= '0;
            absDivisor  <= '0;
            qsr         <= '0;
            rem         <= '0;
            count       <= '0;
            bus.Q       <= '0;
            bus.R       <= '0;
            bus.dbz     <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dividendReg <= bus.Dividend;
                        divisorReg  <= bus.Divisor;
                    end
                end
                INIT: begin
                    if (divisorReg == '0) begin
                        bus.Q   <= '1;
                        bus.R   <= dividendReg;
                        bus.dbz <= 1'b1;
                    end else begin
                        absDivisor <= absVal(divisorReg);
                        qsr        <= absVal(dividendReg);
                        rem        <= '0;
                        count      <= '0;
                        bus.dbz    <= 1'b0;
                    end
                end
                ITER: begin
                    // Restore by keeping the shifted value when the trial goes negative.
                    if (!trial[size]) begin
                        rem <= trial;
                        qsr <= {qsr[size-2:0], 1'b1};
                    end else begin
                        rem <= shifted;
                        qsr <= {qsr[size-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                end
                FIX: begin
                    bus.dbz <= 1'b0;
                    if (overflow) begin
                        bus.Q <= dividendReg;
                        bus.R <= '0;
                    end else begin
                        bus.Q <= signDiff ? -qsr : qsr;
                        bus.R <= dividendReg[size-1] ? -rem[size-1:0] : rem[size-1:0];
                    end
                end
                default: ;
            endcase
            bus.busy <= (stateNext != IDLE);
            bus.done <= (stateNext == DONE);
        end
    end
endmodule
